// File: rtl/iram_loader_pkg.sv
// Shared types and constants for the instruction-RAM loader.
package iram_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int IDX_W  = 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        WR_COMMIT  = 3'd2,
        RD_ADDR    = 3'd3,
        RD_WAIT    = 3'd4,
        RD_SEND    = 3'd5
    } state_t;

endpackage

// File: rtl/iram_loader.sv
// Monitor-side instruction-RAM writer (byte stream -> words) and readback engine (words -> byte stream).
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int IWIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_write,
    input  logic                cmd_read,
    input  logic [IWIDTH+1:2]   cmd_adr,
    input  logic [IWIDTH:0]     cmd_len,
    input  logic                abort,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [IWIDTH+1:2]   i_ram_wadr,
    output logic [31:0]         i_ram_wdata,
    output logic                i_ram_wen,
    output logic [IWIDTH+1:2]   i_ram_radr,
    output logic                i_read_sel,
    input  logic [31:0]         i_ram_rdata,
    output logic                busy,
    output logic                done,
    output logic                rx_err
);

    state_t               state_reg, state_next;
    logic [IWIDTH+1:2]    adr_reg, adr_next;
    logic [IWIDTH:0]      rem_reg, rem_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [31:0]          data_reg, data_next;
    logic                 done_reg, done_next;
    logic                 rx_err_reg, rx_err_next;
    logic                 last_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            adr_reg    <= '0;
            rem_reg    <= '0;
            idx_reg    <= '0;
            data_reg   <= '0;
            done_reg   <= 1'b0;
            rx_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            adr_reg    <= adr_next;
            rem_reg    <= rem_next;
            idx_reg    <= idx_next;
            data_reg   <= data_next;
            done_reg   <= done_next;
            rx_err_reg <= rx_err_next;
        end
    end

    assign last_word = (rem_reg == (IWIDTH+1)'(1));

    always_comb begin
        state_next  = state_reg;
        adr_next    = adr_reg;
        rem_next    = rem_reg;
        idx_next    = idx_reg;
        data_next   = data_reg;
        done_next   = 1'b0;
        rx_err_next = rx_err_reg;

        if (abort) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_write || cmd_read) begin
                        adr_next    = cmd_adr;
                        rem_next    = cmd_len;
                        idx_next    = '0;
                        rx_err_next = 1'b0;
                        if (cmd_len == '0)
                            done_next = 1'b1;
                        else if (cmd_write)
                            state_next = WR_COLLECT;
                        else
                            state_next = RD_ADDR;
                    end
                end
                WR_COLLECT: begin
                    if (rx_valid) begin
                        data_next[{idx_reg, 3'b000} +: BYTE_W] = rx_data;
                        idx_next = idx_reg + IDX_W'(1);
                        if (idx_reg == '1)
                            state_next = WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    adr_next = adr_reg + IWIDTH'(1);
                    rem_next = rem_reg - (IWIDTH+1)'(1);
                    if (last_word) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WR_COLLECT;
                        // A byte landing on the commit cycle starts the next word.
                        if (rx_valid) begin
                            data_next[BYTE_W-1:0] = rx_data;
                            idx_next = IDX_W'(1);
                        end
                    end
                end
                RD_ADDR: state_next = RD_WAIT;
                RD_WAIT: begin
                    data_next  = i_ram_rdata;
                    idx_next   = '0;
                    state_next = RD_SEND;
                end
                RD_SEND: begin
                    if (tx_ready) begin
                        idx_next = idx_reg + IDX_W'(1);
                        if (idx_reg == '1) begin
                            adr_next = adr_reg + IWIDTH'(1);
                            rem_next = rem_reg - (IWIDTH+1)'(1);
                            if (last_word) begin
                                done_next  = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = RD_ADDR;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (rx_valid && !(state_reg == WR_COLLECT || state_reg == WR_COMMIT))
            rx_err_next = 1'b1;
    end

    assign i_ram_wen   = (state_reg == WR_COMMIT) && !abort;
    assign i_ram_wadr  = adr_reg;
    assign i_ram_wdata = data_reg;
    assign i_ram_radr  = adr_reg;
    assign i_read_sel  = (state_reg == RD_ADDR) || (state_reg == RD_WAIT);
    assign tx_valid    = (state_reg == RD_SEND);
    assign tx_data     = data_reg[{idx_reg, 3'b000} +: BYTE_W];
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign rx_err      = rx_err_reg;

endmodule

// File: doc/iram_loader.md
# iram_loader

Monitor-side writer and readback engine for the CPU instruction RAM. Assembles a little-endian byte stream (from the monitor UART receiver) into 32-bit words and writes them to consecutive instruction-RAM word addresses. In the opposite direction it reads words back through the RAM's monitor read port and streams them out as bytes. It drives the instruction-RAM write port and monitor-read select consumed by the fetch stage, and runs only while the CPU is held off.

## Interface

Parameters:
- IWIDTH, 12, instruction-RAM word-address width (RAM holds 2^IWIDTH words)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- cmd_write  in  1  one-cycle pulse, start write session
- cmd_read  in  1  one-cycle pulse, start readback session
- cmd_adr  in  [IWIDTH+1:2]  start word address, sampled with cmd pulse
- cmd_len  in  IWIDTH+1  word count, sampled with cmd pulse; 0 = no-op
- abort  in  1  terminate current session
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle byte strobe; no backpressure
- tx_data  out  8  readback byte
- tx_valid  out  1  readback byte valid
- tx_ready  in  1  consumer accepts byte
- i_ram_wadr  out  [IWIDTH+1:2]  RAM write word address
- i_ram_wdata  out  32  RAM write data
- i_ram_wen  out  1  RAM write enable, one cycle per word
- i_ram_radr  out  [IWIDTH+1:2]  RAM monitor read address
- i_read_sel  out  1  selects monitor read address over PC
- i_ram_rdata  in  32  RAM read data, registered: valid 1 cycle after address
- busy  out  1  session active
- done  out  1  one-cycle pulse, session completed normally
- rx_err  out  1  sticky; byte received outside a write session

## Operation

- States: IDLE, WR_COLLECT, WR_COMMIT, RD_ADDR, RD_WAIT, RD_SEND.
- IDLE: cmd_write with cmd_len≠0 → WR_COLLECT. cmd_read with cmd_len≠0 → RD_ADDR. Both asserted: write wins. cmd_len=0: stay IDLE, done pulses next cycle.
- On an accepted command: load adr and remaining (cmd_len), clear byte index and rx_err.
- WR_COLLECT: each rx_valid stores rx_data into byte lane idx (lane 0 = bits[7:0]), then idx increments. The 4th byte → WR_COMMIT.
- WR_COMMIT (1 cycle): i_ram_wen=1, wadr=adr, wdata=assembled word. Then adr+1 and remaining−1. If remaining was 1: done, IDLE. Otherwise WR_COLLECT. An rx_valid arriving during WR_COMMIT is captured as lane 0 of the next word, never dropped.
- RD_ADDR: i_read_sel=1, radr=adr → RD_WAIT.
- RD_WAIT: i_read_sel=1, radr held; capture i_ram_rdata into the shift register → RD_SEND.
- RD_SEND: tx_data = lane idx (LSB lane first). Each tx_valid&tx_ready advances idx. After the 4th accept: adr+1, remaining−1. If remaining was 1: done, IDLE. Otherwise RD_ADDR.
- Address increments modulo 2^IWIDTH (wraps to 0). cmd_len > 2^IWIDTH rewrites/rereads wrapped words; no error.
- rx_valid in any state except WR_COLLECT/WR_COMMIT: byte dropped, rx_err set.
- abort (any state, highest priority after reset): next state IDLE, partial word discarded, no write, no done, tx_valid drops.
- Commands while busy are ignored.

## Timing

- Reset: all outputs 0; state IDLE; adr, remaining, idx, data registers 0.
- busy=1 in every state except IDLE, starting the cycle after the accepted command.
- i_ram_wen asserts the cycle after the 4th byte's rx_valid. Back-to-back bytes are sustained indefinitely.
- Readback: tx_valid first rises 2 cycles after entering RD_ADDR. While tx_valid=1 and tx_ready=0, tx_valid and tx_data stay stable.
- done is coincident with the transition to IDLE and lasts 1 cycle.
- i_read_sel is 0 outside RD_ADDR/RD_WAIT, so PC fetch addressing is otherwise unaffected.

## Structure

- Shared package: state enum, byte-lane index width (2), RX/TX byte width constant.
- No sub-module needed; a single FSM with a datapath (address counter, remaining counter, 32-bit assemble/shift register).

## Test plan

- Write cmd_adr=0x010, cmd_len=2, bytes 13 00 00 00 93 00 10 00 → writes 0x00000013@0x010 and 0x00100093@0x011, done once, busy low after.
- Read cmd_adr=0x010, cmd_len=2, tx_ready=1 → i_read_sel pulses, tx bytes 13 00 00 00 93 00 10 00, then done.
- Readback with tx_ready toggling every other cycle → same byte sequence, tx_data stable while stalled, no bytes lost.
- Write cmd_adr=0xFFF, cmd_len=2 (IWIDTH=12) → writes @0xFFF then @0x000.
- abort after 2 bytes of a write → no i_ram_wen, no done, IDLE. A stray rx_valid while IDLE → rx_err=1, cleared by the next command.
- cmd_write and cmd_read in the same cycle → write session only. cmd_len=0 → done next cycle, no RAM access.
